// File: rtl/req_to_valid_bridge.sv
// req_to_valid_bridge
// Accepts words from an upstream four-phase req/ack requester and hands them
// to a downstream valid/ready consumer through a DEPTH-entry
// first-word-fall-through buffer. Both sides share one clock; the buffer
// decouples the slow handshake from the streaming consumer.

`ifndef WIDTH
`define WIDTH 8
`endif

module req_to_valid_bridge #(
  parameter int WIDTH = `WIDTH,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   req,
  input  logic [WIDTH-1:0]       data_in,
  output logic                   ack,
  output logic                   valid,
  output logic [WIDTH-1:0]       data_out,
  input  logic                   ready,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_REL = 1'b1
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             push;
  logic             pop;

  // Upstream handshake: capture once per request in IDLE, then hold ack
  // until the requester drops req. Space is judged on the registered count,
  // so a slot freed by a pop becomes usable one edge later.
  always_comb begin
    // NOTE: every signal written here gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    state_nxt = state;
    push      = 1'b0;
    unique case (state)
      IDLE: begin
        if (en && req && (count != FULL)) begin
          push      = 1'b1;
          state_nxt = WAIT_REL;
        end
      end
      WAIT_REL: begin
        if (!req) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register for the upstream handshake.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block evaluation order.
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ack comes straight off the state flop, so it is registered.
  assign ack = (state == WAIT_REL);

  // Downstream side: a word is presented whenever the buffer is non-empty,
  // and a pop happens on any edge where it is also accepted.
  assign valid    = (count != '0);
  assign pop      = valid && ready;
  assign data_out = mem[rd_ptr];

  // Write and read pointers; they wrap naturally at DEPTH.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  // Occupancy: a simultaneous push and pop leaves it unchanged.
  always_ff @(posedge clk) begin
    if (!rst) begin
      count <= '0;
    end else begin
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Buffer storage, cleared on reset so data_out reads zero afterwards.
  always_ff @(posedge clk) begin
    // NOTE: storage arrays are normally left unreset; this one is cleared
    // because data_out must read zero after reset, and DEPTH is small.
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (push) begin
      mem[wr_ptr] <= data_in;
    end
  end

endmodule

// File: tb/tb_req_to_valid_bridge.sv
// Self-checking bench for req_to_valid_bridge: directed scenarios followed by
// a randomized phase. A queue-based reference model predicts occupancy and
// word order; a monitor compares the DUT against it every cycle.

module tb_req_to_valid_bridge;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  logic             req;
  logic [WIDTH-1:0] data_in;
  logic             ack;
  logic             valid;
  logic [WIDTH-1:0] data_out;
  logic             ready;
  logic [CW-1:0]    count;

  int total = 0;
  int bad   = 0;
  bit check_en = 1'b0;

  // Reference model: number of buffered words, whether a handshake is open,
  // and the words the consumer must see, in order.
  int               m_cnt  = 0;
  bit               m_busy = 1'b0;
  logic [WIDTH-1:0] exp_q[$];

  req_to_valid_bridge #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .req      (req),
    .data_in  (data_in),
    .ack      (ack),
    .valid    (valid),
    .data_out (data_out),
    .ready    (ready),
    .count    (count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: advance on each edge from the inputs the bench drove.
  always @(posedge clk) begin
    bit do_pop;
    bit do_cap;
    if (!rst) begin
      m_cnt  = 0;
      m_busy = 1'b0;
      exp_q.delete();
    end else begin
      do_pop = (m_cnt > 0) && ready;
      do_cap = !m_busy && en && req && (m_cnt < DEPTH);
      if (m_busy && !req) m_busy = 1'b0;
      else if (do_cap)    m_busy = 1'b1;
      m_cnt = m_cnt + int'(do_cap) - int'(do_pop);
      if (do_cap) exp_q.push_back(data_in);
    end
  end

  // Monitor: on the falling edge compare handshake state and, when the DUT
  // offers a word that will be accepted, the word itself.
  always @(negedge clk) begin
    if (check_en) begin
      check("ack", 32'(ack), 32'(m_busy));
      check("valid", 32'(valid), 32'(m_cnt != 0));
      check("count", 32'(count), 32'(m_cnt));
      if (rst && valid && ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL pop_unexpected: got word %0h expected none at %0t", data_out, $time);
        end else begin
          check("data_out", 32'(data_out), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete four-phase transfer; waits for ack with a cycle budget.
  task automatic xfer(input logic [WIDTH-1:0] d);
    bit got = 1'b0;
    req     = 1'b1;
    data_in = d;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (ack) begin
        got = 1'b1;
        break;
      end
    end
    total++;
    if (!got) begin
      bad++;
      $display("FAIL xfer_timeout: got no ack expected ack for word %0h", d);
    end
    req = 1'b0;
    tick();
  endtask

  initial begin
    int bias;
    rst     = 1'b0;
    en      = 1'b1;
    req     = 1'b1;
    data_in = 8'h11;
    ready   = 1'b0;

    // Reset held two cycles with a pending request.
    @(posedge clk);
    check_en = 1'b1;
    @(posedge clk);
    #1;
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_data", 32'(data_out), 32'd0);
    rst = 1'b1;
    tick();
    check("post_rst_ack", 32'(ack), 32'd1);
    check("post_rst_data", 32'(data_out), 32'h11);
    req   = 1'b0;
    ready = 1'b1;
    tick();
    check("post_rst_drain", 32'(count), 32'd0);

    // Single transfer with the consumer ready.
    req     = 1'b1;
    data_in = 8'hA5;
    tick();
    check("single_ack", 32'(ack), 32'd1);
    check("single_valid", 32'(valid), 32'd1);
    check("single_data", 32'(data_out), 32'hA5);
    req = 1'b0;
    tick();
    check("single_release", 32'(ack), 32'd0);
    check("single_count", 32'(count), 32'd0);

    // Fill to full with the consumer stalled.
    ready = 1'b0;
    for (int i = 1; i <= 4; i++) xfer(8'(i));
    check("full_count", 32'(count), 32'd4);
    req     = 1'b1;
    data_in = 8'h05;
    repeat (3) begin
      tick();
      check("full_no_ack", 32'(ack), 32'd0);
    end
    ready = 1'b1;
    tick();
    ready = 1'b0;
    check("full_pop_ack", 32'(ack), 32'd0);
    check("full_pop_count", 32'(count), 32'd3);
    check("full_pop_head", 32'(data_out), 32'h02);
    tick();
    check("refill_ack", 32'(ack), 32'd1);
    check("refill_count", 32'(count), 32'd4);
    req = 1'b0;
    tick();

    // Drain one word per cycle, then transfers across the pointer wrap.
    ready = 1'b1;
    for (int i = 2; i <= 5; i++) begin
      check("drain_data", 32'(data_out), 32'(i));
      tick();
    end
    check("drain_empty", 32'(valid), 32'd0);
    for (int i = 6; i <= 8; i++) xfer(8'(i));

    // Simultaneous push and pop at count 2.
    ready = 1'b0;
    xfer(8'h09);
    xfer(8'h0A);
    check("pp_pre", 32'(count), 32'd2);
    ready   = 1'b1;
    req     = 1'b1;
    data_in = 8'h0B;
    tick();
    check("pp_count", 32'(count), 32'd2);
    check("pp_head", 32'(data_out), 32'h0A);
    ready = 1'b0;
    req   = 1'b0;
    tick();
    ready = 1'b1;
    repeat (3) tick();
    ready = 1'b0;

    // Enable gating.
    en      = 1'b0;
    req     = 1'b1;
    data_in = 8'h20;
    repeat (3) begin
      tick();
      check("en_block", 32'(ack), 32'd0);
    end
    check("en_block_count", 32'(count), 32'd0);
    en = 1'b1;
    tick();
    check("en_capture", 32'(ack), 32'd1);
    en = 1'b0;
    tick();
    check("en_hold", 32'(ack), 32'd1);
    req = 1'b0;
    tick();
    check("en_release", 32'(ack), 32'd0);
    ready = 1'b1;
    tick();
    check("en_drain", 32'(count), 32'd0);
    ready = 1'b0;
    en    = 1'b1;

    // Randomized phase: requester obeys four-phase rules, consumer stalls
    // with a bias that changes periodically, occasional resets.
    bias = 50;
    for (int c = 0; c < 3000; c++) begin
      tick();
      if (c % 200 == 0) bias = int'($urandom_range(10, 90));
      rst   = ($urandom_range(0, 399) != 0);
      en    = ($urandom_range(0, 7) != 0);
      ready = ($urandom_range(0, 99) < bias);
      if (req) begin
        if (ack && $urandom_range(0, 3) != 0) req = 1'b0;
      end else if ($urandom_range(0, 2) == 0) begin
        req     = 1'b1;
        data_in = 8'($urandom);
      end
    end

    // Let everything drain out.
    rst   = 1'b1;
    req   = 1'b0;
    ready = 1'b1;
    repeat (10) tick();
    check("final_empty", 32'(exp_q.size()), 32'd0);
    check("final_count", 32'(count), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/req_to_valid_bridge.md
# req_to_valid_bridge

Reverse-direction bridge: accepts words from an upstream four-phase req/ack requester and delivers them to a downstream valid/ready consumer through a DEPTH-entry first-word-fall-through buffer. It decouples the slow handshake domain from the streaming consumer on the same clock, for return-path traffic from the receiver side toward the sender side.

## Interface
- WIDTH, default `` `WIDTH `` from defines.sv, data word width
- DEPTH, default 4, buffer entries; power of two, ≥2
- clk  input  1  single clock, all logic on rising edge
- rst  input  1  synchronous, active-low reset (sampled on rising clk; 0 = reset)
- en  input  1  capture enable for the upstream side
- req  input  1  upstream four-phase request; data_in valid while high
- data_in  input  WIDTH  upstream data word
- ack  output  1  upstream acknowledge, registered
- valid  output  1  downstream word available
- data_out  output  WIDTH  downstream word (head of buffer)
- ready  input  1  downstream accepts data_out
- count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH

## Operation
- Upstream FSM, two states:
  - IDLE: ack=0. At an edge with en=1, req=1, count<DEPTH: write data_in at wr_ptr, wr_ptr+1, go WAIT_REL. Otherwise stay.
  - WAIT_REL: ack=1. At an edge with req=0: go IDLE (ack=0). While req=1, stay; no further capture.
- en=0 blocks new captures only; a transfer already in WAIT_REL still completes. Downstream draining is independent of en.
- Downstream: valid = (count≠0); data_out = mem[rd_ptr] (FWFT). Pop at any edge with valid=1 and ready=1: rd_ptr+1.
- Pointers are $clog2(DEPTH) bits, wrap DEPTH-1→0 naturally.
- count: +1 on push only, −1 on pop only, unchanged on simultaneous push and pop.
- Full (count=DEPTH): req held high is not captured, ack stays 0 until space frees. Space freed by a pop at edge k is usable for a capture at edge k+1 at the earliest (push condition uses registered count).
- Empty: valid=0; ready ignored, no underflow, count never below 0.
- No data-dependent behaviour; words leave in capture order, unmodified.

## Timing
- Reset (rst=0 at an edge): next cycle state=IDLE, ack=0, valid=0, count=0, pointers=0, all entries cleared so data_out=0. Applies mid-transfer: buffered words discarded, ack drops even if req high; after release a still-high req is captured as a new word (if en=1).
- Capture latency: req sampled high at edge k (IDLE, space, en) → ack=1 and valid=1 (if previously empty) after edge k; data_out shows the word in the same cycle.
- Release: req sampled low at edge m>k → ack=0 after edge m. Minimum upstream cycle: capture edge k, release edge k+1, next capture edge k+2.
- Downstream throughput: one pop per cycle while count>0 and ready=1.
- Upstream throughput ≤ one word per two cycles; buffer fills only if consumer stalls.

## Test plan
- Reset: hold rst=0 two cycles with req=1, en=1 → ack=0, valid=0, count=0, data_out=0; release rst → word captured at first edge, ack=1 next cycle.
- Single transfer, ready=1: req=1, data_in=0xA5 → ack=1 and valid=1, data_out=0xA5 one cycle after capture edge; pop same cycle, count returns to 0; req low → ack=0 next cycle.
- Fill to full, ready=0: four transfers 0x01..0x04 → count=4; fifth req held high gets no ack; assert ready for one cycle → 0x01 popped, fifth word captured the following edge, ack rises, count=4.
- Drain and wrap: after above, ready=1 continuously → data_out sequence 0x02,0x03,0x04,0x05, one per cycle, valid drops after last; further transfers across pointer wrap preserve order.
- Simultaneous push/pop at count=2 → count stays 2, order intact.
- en gating: en=0 with req=1 in IDLE → no ack, count unchanged; en dropped during WAIT_REL → ack still falls after req low; downstream drain continues with en=0.
